// File: rtl/axi_arb_pkg.sv
// Shared definitions for the two-master AXI4 read arbiter.
//   state_t     : one-hot FSM encoding (IDLE / AR / R)
//   M_IFU/M_LSU : grant values for the ICache refill and LSU load masters
//   BURST_*     : AXI burst-type encodings, for stimulus and checkers
`timescale 1ns/1ps
package axi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_AR   = 3'b010,
        ST_R    = 3'b100
    } state_t;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-only bus (AR + R channels).
//   master modport : request issuer (drives AR and rready, receives R)
//   slave  modport : request target (drives arready and R)
// The arbiter uses the slave modport toward each master port and the
// master modport toward the shared memory read port.
`timescale 1ns/1ps
interface axi_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [ID_W-1:0]   rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin pick (purely combinational).
//   req[1:0]   : arvalid of LSU (bit 1) and ICache (bit 0)
//   last_grant : master that owned the previous completed burst
//   any_req    : at least one requester present
//   pick       : winning master (M_IFU / M_LSU)
// A lone requester always wins; on contention the master that did not
// hold the previous grant wins.
`timescale 1ns/1ps
module rr_arb2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       any_req,
    output logic       pick
);
    always_comb begin
        any_req = |req;
        pick    = M_IFU;
        case (req)
            2'b01:   pick = M_IFU;
            2'b10:   pick = M_LSU;
            2'b11:   pick = ~last_grant;
            default: pick = M_IFU;
        endcase
    end
endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master, one-slave AXI4 read arbiter. ICache refill is master 0,
// LSU load path is master 1. One transaction in flight; the whole burst
// drains before the next arbitration.
//   clock, reset : system clock, asynchronous active-high reset
//   m0, m1       : master-facing read ports (slave modport)
//   s            : memory-facing read port (master modport)
//   err_len      : sticky, a burst's rlast did not land on beat arlen+1
//   busy         : arbiter is not idle
`timescale 1ns/1ps
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter bit PRIO_M1 = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    axi_rd_arbiter_if.slave   m0,
    axi_rd_arbiter_if.slave   m1,
    axi_rd_arbiter_if.master  s,
    output logic              err_len,
    output logic              busy
);
    state_t     state;
    logic       grant;
    logic       last_grant;
    logic [7:0] beat_cnt;
    logic [7:0] len_r;

    logic       pick_any;
    logic       pick;

    logic       in_ar;
    logic       in_r;
    logic       r_beat;
    logic       r_to_m0;
    logic       r_to_m1;

    // AR fields and rready of the granted master
    logic              sel_arvalid;
    logic [ADDR_W-1:0] sel_araddr;
    logic [ID_W-1:0]   sel_arid;
    logic [7:0]        sel_arlen;
    logic [2:0]        sel_arsize;
    logic [1:0]        sel_arburst;
    logic              sel_rready;

    logic [DATA_W-1:0] r_data;
    logic [ID_W-1:0]   r_id;

    rr_arb2 u_rr (
        .req        ({m1.arvalid, m0.arvalid}),
        .last_grant (last_grant),
        .any_req    (pick_any),
        .pick       (pick)
    );

    always_comb begin
        if (grant == M_LSU) begin
            sel_arvalid = m1.arvalid;
            sel_araddr  = m1.araddr;
            sel_arid    = m1.arid;
            sel_arlen   = m1.arlen;
            sel_arsize  = m1.arsize;
            sel_arburst = m1.arburst;
            sel_rready  = m1.rready;
        end else begin
            sel_arvalid = m0.arvalid;
            sel_araddr  = m0.araddr;
            sel_arid    = m0.arid;
            sel_arlen   = m0.arlen;
            sel_arsize  = m0.arsize;
            sel_arburst = m0.arburst;
            sel_rready  = m0.rready;
        end
    end

    assign in_ar   = (state == ST_AR);
    assign in_r    = (state == ST_R);
    assign busy    = (state != ST_IDLE);
    assign r_beat  = in_r & s.rvalid & s.rready;
    assign r_to_m0 = in_r & (grant == M_IFU);
    assign r_to_m1 = in_r & (grant == M_LSU);
    assign r_data  = s.rdata;
    assign r_id    = s.rid;

    // AR forward is gated by state only, so s.arvalid never depends on
    // anything on the R channel.
    assign s.arvalid = in_ar & sel_arvalid;
    assign s.araddr  = in_ar ? sel_araddr  : '0;
    assign s.arid    = in_ar ? sel_arid    : '0;
    assign s.arlen   = in_ar ? sel_arlen   : '0;
    assign s.arsize  = in_ar ? sel_arsize  : '0;
    assign s.arburst = in_ar ? sel_arburst : '0;

    assign m0.arready = in_ar & (grant == M_IFU) & s.arready;
    assign m1.arready = in_ar & (grant == M_LSU) & s.arready;

    assign s.rready = in_r & sel_rready;

    // The non-granted master sees an all-zero R channel.
    assign m0.rvalid = r_to_m0 & s.rvalid;
    assign m0.rdata  = r_to_m0 ? r_data  : '0;
    assign m0.rresp  = r_to_m0 ? s.rresp : '0;
    assign m0.rlast  = r_to_m0 & s.rlast;
    assign m0.rid    = r_to_m0 ? r_id    : '0;

    assign m1.rvalid = r_to_m1 & s.rvalid;
    assign m1.rdata  = r_to_m1 ? r_data  : '0;
    assign m1.rresp  = r_to_m1 ? s.rresp : '0;
    assign m1.rlast  = r_to_m1 & s.rlast;
    assign m1.rid    = r_to_m1 ? r_id    : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= M_IFU;
            last_grant <= ~PRIO_M1;
            beat_cnt   <= '0;
            len_r      <= '0;
            err_len    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant <= pick;
                        state <= ST_AR;
                    end
                end
                // A granted master that drops arvalid keeps the grant;
                // we simply wait here.
                ST_AR: begin
                    if (s.arvalid && s.arready) begin
                        len_r    <= sel_arlen;
                        beat_cnt <= '0;
                        state    <= ST_R;
                    end
                end
                // beat_cnt counts beats already accepted, so the rlast beat
                // is correct exactly when beat_cnt == arlen.
                ST_R: begin
                    if (r_beat) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (s.rlast) begin
                            if (beat_cnt != len_r) err_len <= 1'b1;
                            last_grant <= grant;
                            state      <= ST_IDLE;
                        end else if (beat_cnt == len_r) begin
                            // Burst overran its length; keep draining to rlast.
                            err_len <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
`timescale 1ns/1ps
module tb_axi_rd_arbiter;
    import axi_arb_pkg::*;

    localparam bit PRIO_M1 = 1'b1;

    logic clock = 1'b0;
    logic reset;
    logic err_len;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: previous winner and sticky length error
    int m_last;
    bit m_err;

    axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m0_if ();
    axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m1_if ();
    axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) s_if ();

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .PRIO_M1(PRIO_M1)) dut (
        .clock   (clock),
        .reset   (reset),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .err_len (err_len),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    function automatic int model_pick(input logic [1:0] req);
        if (req == 2'b01) return 0;
        if (req == 2'b10) return 1;
        return 1 - m_last;
    endfunction

    task automatic model_reset();
        m_last = PRIO_M1 ? 0 : 1;
        m_err  = 1'b0;
    endtask

    task automatic clear_inputs();
        m0_if.arvalid = 0; m0_if.araddr = 0; m0_if.arid = 0; m0_if.arlen = 0;
        m0_if.arsize = 0; m0_if.arburst = 0; m0_if.rready = 0;
        m1_if.arvalid = 0; m1_if.araddr = 0; m1_if.arid = 0; m1_if.arlen = 0;
        m1_if.arsize = 0; m1_if.arburst = 0; m1_if.rready = 0;
        s_if.arready = 0; s_if.rvalid = 0; s_if.rdata = 0; s_if.rresp = 0;
        s_if.rlast = 0; s_if.rid = 0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // Drives one complete transaction starting at a negedge with the arbiter
    // idle; returns what it observed. stall >= 0: rvalid held high, owner
    // rready low for 'stall' cycles then high. stall < 0: random gaps.
    task automatic run_burst(input logic [1:0] req, input logic [7:0] l0, input logic [7:0] l1,
                             input logic [31:0] a0, input logic [31:0] a1, input logic [1:0] bt,
                             input int nb_force, input int stall,
                             output int owner, output int fields_bad, output int beats_good,
                             output int leak, output int stalled, output logic busy_after);
        int nb, b, st;
        bit done, pend;
        logic own_rdy;
        logic o_rvalid, o_rlast, x_rvalid, x_rlast;
        logic [31:0] o_rdata, x_rdata;
        logic [1:0] o_rresp;
        logic [3:0] o_rid;
        owner = -1; fields_bad = 0; beats_good = 0; leak = 0; stalled = 0;
        st = stall; done = 0; pend = 0;
        m0_if.arvalid = req[0]; m0_if.araddr = a0; m0_if.arlen = l0;
        m0_if.arid = 4'($urandom); m0_if.arsize = 3'd2; m0_if.arburst = bt;
        m1_if.arvalid = req[1]; m1_if.araddr = a1; m1_if.arlen = l1;
        m1_if.arid = 4'($urandom); m1_if.arsize = 3'd2; m1_if.arburst = bt;
        s_if.rvalid = 0; s_if.rlast = 0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            s_if.arready = (cyc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (cyc == 0 && (s_if.arvalid || busy || m0_if.arready || m1_if.arready)) leak++;
            if (m0_if.arready && m1_if.arready) leak++;
            if ((m0_if.arready || m1_if.arready) && !s_if.arready) leak++;
            if (s_if.arvalid && s_if.arready) begin
                done  = 1;
                owner = m1_if.arready ? 1 : (m0_if.arready ? 0 : -2);
                if (owner == 1) begin
                    if (s_if.araddr !== m1_if.araddr || s_if.arid !== m1_if.arid ||
                        s_if.arlen !== m1_if.arlen || s_if.arburst !== m1_if.arburst ||
                        s_if.arsize !== m1_if.arsize) fields_bad++;
                end else begin
                    if (s_if.araddr !== m0_if.araddr || s_if.arid !== m0_if.arid ||
                        s_if.arlen !== m0_if.arlen || s_if.arburst !== m0_if.arburst ||
                        s_if.arsize !== m0_if.arsize) fields_bad++;
                end
            end
            @(negedge clock);
        end
        s_if.arready = 0;
        if (owner == 0) m0_if.arvalid = 0;
        if (owner == 1) m1_if.arvalid = 0;
        if (owner >= 0) begin
            nb = (nb_force > 0) ? nb_force : int'((owner == 1) ? l1 : l0) + 1;
            b = 0;
            for (int cyc = 0; cyc < 80 && b < nb; cyc++) begin
                if (!pend) begin
                    s_if.rvalid = (stall >= 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                    s_if.rdata  = $urandom;
                    s_if.rresp  = 2'($urandom);
                    s_if.rid    = 4'($urandom);
                    s_if.rlast  = (b == nb - 1);
                end
                if (st > 0) own_rdy = 1'b0;
                else own_rdy = (stall >= 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                m0_if.rready = (owner == 0) ? own_rdy : 1'($urandom);
                m1_if.rready = (owner == 1) ? own_rdy : 1'($urandom);
                #1;
                o_rvalid = (owner == 1) ? m1_if.rvalid : m0_if.rvalid;
                o_rdata  = (owner == 1) ? m1_if.rdata  : m0_if.rdata;
                o_rresp  = (owner == 1) ? m1_if.rresp  : m0_if.rresp;
                o_rid    = (owner == 1) ? m1_if.rid    : m0_if.rid;
                o_rlast  = (owner == 1) ? m1_if.rlast  : m0_if.rlast;
                x_rvalid = (owner == 1) ? m0_if.rvalid : m1_if.rvalid;
                x_rdata  = (owner == 1) ? m0_if.rdata  : m1_if.rdata;
                x_rlast  = (owner == 1) ? m0_if.rlast  : m1_if.rlast;
                if (s_if.rready !== own_rdy) leak++;
                if (s_if.arvalid || m0_if.arready || m1_if.arready || !busy) leak++;
                if (o_rvalid !== s_if.rvalid) leak++;
                if (x_rvalid !== 1'b0 || x_rdata !== '0 || x_rlast !== 1'b0) leak++;
                if (s_if.rvalid && !s_if.rready) stalled++;
                if (s_if.rvalid && own_rdy) begin
                    if (o_rdata === s_if.rdata && o_rresp === s_if.rresp &&
                        o_rid === s_if.rid && o_rlast === s_if.rlast) beats_good++;
                    b++;
                    pend = 0;
                end else begin
                    pend = s_if.rvalid;
                end
                if (st > 0) st--;
                @(negedge clock);
            end
        end
        s_if.rvalid = 0; s_if.rlast = 0; m0_if.rready = 0; m1_if.rready = 0;
        #1;
        busy_after = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        m0_if.arvalid = 1; m1_if.arvalid = 1; s_if.arready = 1; s_if.rvalid = 1;
        m0_if.rready = 1; m1_if.rready = 1;
        repeat (2) @(negedge clock);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_len); end
        n_checks++; if (s_if.arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_s_arvalid: got %b want 0", s_if.arvalid); end
        n_checks++; if (s_if.rready !== 1'b0) begin n_fail++; $display("FAIL reset_s_rready: got %b want 0", s_if.rready); end
        n_checks++; if ({m0_if.arready, m1_if.arready} !== 2'b00) begin n_fail++; $display("FAIL reset_arready: got %b want 00", {m0_if.arready, m1_if.arready}); end
        n_checks++; if ({m0_if.rvalid, m1_if.rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", {m0_if.rvalid, m1_if.rvalid}); end
        clear_inputs();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        #1;
        n_checks++; if (busy !== 1'b0 || s_if.arvalid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got busy=%b arvalid=%b want 0 0", busy, s_if.arvalid); end
        @(negedge clock);
    endtask

    task automatic test_lone_icache();
        int own, fb, bg, lk, st, exp;
        logic ba;
        exp = model_pick(2'b01);
        run_burst(2'b01, 8'd1, 8'd0, 32'h8000_0008, 32'h0, BURST_WRAP, 0, 0, own, fb, bg, lk, st, ba);
        n_checks++; if (own !== exp) begin n_fail++; $display("FAIL lone_owner: got %0d want %0d", own, exp); end
        n_checks++; if (fb !== 0) begin n_fail++; $display("FAIL lone_ar_fields: got %0d bad want 0", fb); end
        n_checks++; if (bg !== 2) begin n_fail++; $display("FAIL lone_beats: got %0d want 2", bg); end
        n_checks++; if (lk !== 0) begin n_fail++; $display("FAIL lone_isolation: got %0d violations want 0", lk); end
        n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL lone_busy_after: got %b want 0", ba); end
        n_checks++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL lone_err: got %b want 0", err_len); end
        m_last = exp;
    endtask

    task automatic test_simultaneous();
        int own, fb, bg, lk, st, exp;
        logic ba;
        logic [7:0] l0, l1;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            l0 = 8'($urandom_range(0, 3)); l1 = 8'($urandom_range(0, 3));
            exp = model_pick((i == 0) ? 2'b11 : 2'b01);
            run_burst((i == 0) ? 2'b11 : 2'b01, l0, l1, $urandom, $urandom, BURST_INCR, 0, -1, own, fb, bg, lk, st, ba);
            n_checks++; if (own !== exp) begin n_fail++; $display("FAIL simul_owner[%0d]: got %0d want %0d", i, own, exp); end
            n_checks++; if (bg !== int'((exp == 1) ? l1 : l0) + 1 || lk !== 0) begin n_fail++; $display("FAIL simul_burst[%0d]: got beats=%0d viol=%0d want %0d 0", i, bg, lk, int'((exp == 1) ? l1 : l0) + 1); end
            m_last = exp;
        end
    endtask

    task automatic test_contention();
        int own, fb, bg, lk, st, exp;
        logic ba;
        logic [7:0] l0, l1;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            l0 = 8'($urandom_range(0, 3)); l1 = 8'($urandom_range(0, 3));
            exp = model_pick(2'b11);
            run_burst(2'b11, l0, l1, $urandom, $urandom, BURST_INCR, 0, -1, own, fb, bg, lk, st, ba);
            n_checks++; if (own !== exp) begin n_fail++; $display("FAIL contend_owner[%0d]: got %0d want %0d", i, own, exp); end
            n_checks++; if (bg !== int'((exp == 1) ? l1 : l0) + 1 || lk !== 0 || fb !== 0) begin n_fail++; $display("FAIL contend_burst[%0d]: got beats=%0d viol=%0d fields=%0d", i, bg, lk, fb); end
            m_last = exp;
        end
    endtask

    task automatic test_len_mismatch();
        int own, fb, bg, lk, st, exp;
        logic ba;
        apply_reset();
        run_burst(2'b01, 8'd3, 8'd0, $urandom, $urandom, BURST_INCR, 2, 0, own, fb, bg, lk, st, ba);
        n_checks++; if (own !== 0 || bg !== 2) begin n_fail++; $display("FAIL short_burst: got owner=%0d beats=%0d want 0 2", own, bg); end
        n_checks++; if (err_len !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b want 1", err_len); end
        n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL short_idle: got busy=%b want 0", ba); end
        m_last = 0; m_err = 1;
        for (int i = 0; i < 2; i++) begin
            exp = model_pick(2'b10);
            run_burst(2'b10, 8'd0, 8'($urandom_range(0, 3)), $urandom, $urandom, BURST_FIXED, 0, -1, own, fb, bg, lk, st, ba);
            n_checks++; if (err_len !== 1'(m_err)) begin n_fail++; $display("FAIL sticky_err[%0d]: got %b want %b", i, err_len, m_err); end
            m_last = exp;
        end
        apply_reset();
        #1;
        n_checks++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", err_len); end
    endtask

    task automatic test_backpressure();
        int own, fb, bg, lk, st;
        logic ba;
        apply_reset();
        run_burst(2'b10, 8'd0, 8'd0, $urandom, $urandom, BURST_INCR, 0, 3, own, fb, bg, lk, st, ba);
        n_checks++; if (own !== 1) begin n_fail++; $display("FAIL bp_owner: got %0d want 1", own); end
        n_checks++; if (st !== 3) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d want 3", st); end
        n_checks++; if (bg !== 1 || lk !== 0) begin n_fail++; $display("FAIL bp_beat: got beats=%0d viol=%0d want 1 0", bg, lk); end
        n_checks++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL bp_no_count: got err=%b want 0", err_len); end
        m_last = 1;
    endtask

    task automatic test_async_reset();
        int own, fb, bg, lk, st;
        logic ba;
        apply_reset();
        m0_if.arvalid = 1; m0_if.arlen = 8'd3; m0_if.araddr = $urandom; s_if.arready = 1;
        @(negedge clock);
        #1;
        n_checks++; if (s_if.arvalid !== 1'b1) begin n_fail++; $display("FAIL ar_phase: got arvalid=%b want 1", s_if.arvalid); end
        @(negedge clock);
        m0_if.arvalid = 0; s_if.arready = 0;
        s_if.rvalid = 1; s_if.rdata = $urandom; s_if.rlast = 0; m0_if.rready = 1;
        #1;
        n_checks++; if (busy !== 1'b1 || s_if.rready !== 1'b1 || m0_if.rvalid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_r: got busy=%b rready=%b rvalid=%b want 1 1 1", busy, s_if.rready, m0_if.rvalid); end
        @(posedge clock);
        #2;
        reset = 1'b1;
        m0_if.arvalid = 1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", busy); end
        n_checks++; if (s_if.arvalid !== 1'b0 || s_if.rready !== 1'b0) begin n_fail++; $display("FAIL areset_slave: got arvalid=%b rready=%b want 0 0", s_if.arvalid, s_if.rready); end
        n_checks++; if ({m0_if.rvalid, m1_if.rvalid} !== 2'b00) begin n_fail++; $display("FAIL areset_rvalid: got %b want 00", {m0_if.rvalid, m1_if.rvalid}); end
        @(negedge clock);
        clear_inputs();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        run_burst(2'b01, 8'd2, 8'd0, $urandom, $urandom, BURST_INCR, 0, -1, own, fb, bg, lk, st, ba);
        n_checks++; if (own !== 0 || bg !== 3 || lk !== 0 || err_len !== 1'b0) begin n_fail++; $display("FAIL after_areset: got owner=%0d beats=%0d viol=%0d err=%b want 0 3 0 0", own, bg, lk, err_len); end
        m_last = 0;
    endtask

    task automatic test_random();
        int own, fb, bg, lk, st, exp, nbf, exp_nb, ln;
        logic ba;
        logic [1:0] req;
        logic [7:0] l0, l1;
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            req = 2'($urandom_range(1, 3));
            l0 = 8'($urandom_range(0, 3)); l1 = 8'($urandom_range(0, 3));
            nbf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            exp = model_pick(req);
            ln = int'((exp == 1) ? l1 : l0);
            exp_nb = (nbf > 0) ? nbf : ln + 1;
            run_burst(req, l0, l1, $urandom, $urandom, 2'($urandom_range(0, 2)), nbf, -1, own, fb, bg, lk, st, ba);
            if (exp_nb != ln + 1) m_err = 1;
            m_last = exp;
            n_checks++; if (own !== exp) begin n_fail++; $display("FAIL rnd_owner[%0d]: got %0d want %0d", i, own, exp); end
            n_checks++; if (bg !== exp_nb || lk !== 0 || fb !== 0 || ba !== 1'b0) begin n_fail++; $display("FAIL rnd_burst[%0d]: got beats=%0d viol=%0d fields=%0d busy=%b want %0d 0 0 0", i, bg, lk, fb, ba, exp_nb); end
            n_checks++; if (err_len !== 1'(m_err)) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", i, err_len, m_err); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lone_icache();
        test_simultaneous();
        test_contention();
        test_len_mismatch();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-master, one-slave AXI4 read-channel arbiter. It shares the single memory read port between instruction fetch (ICache refill, master 0) and the LSU load path (master 1).
- Sits between the ICache/LSU read ports and the memory/crossbar read slave.
- Carries one outstanding transaction at a time. The whole burst completes before re-arbitration.
- Round-robin fairness, plus a burst-length checker that raises a sticky error.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.
- ID_W, 4, arid/rid width. Passed through unchanged.
- PRIO_M1, 1, winner on a simultaneous request when no prior grant exists (0 = ICache, 1 = LSU).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mN_arvalid/mN_arready  in/out  1 each  AR handshake, master N (N = 0, 1)
- mN_araddr  in  ADDR_W  AR address
- mN_arid  in  ID_W  AR id
- mN_arlen  in  8  AR burst length
- mN_arsize  in  3  AR beat size
- mN_arburst  in  2  AR burst type
- mN_rvalid/mN_rready  out/in  1 each  R handshake
- mN_rdata  out  DATA_W  R data
- mN_rresp  out  2  R response
- mN_rlast  out  1  R last beat
- mN_rid  out  ID_W  R id
- s_ar*  out  (widths as above)  slave AR channel; s_arready is an input
- s_r*  in  (widths as above)  slave R channel; s_rready is an output
- err_len  out  1  sticky: rlast arrived on a beat count different from arlen+1
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, grant = 0, last_grant = !PRIO_M1, beat_cnt = 0, err_len = 0.
  - All valid/ready outputs to masters and slave are 0 during and after reset until a request arrives.
- States:
  - IDLE: if any mN_arvalid, latch grant from the round-robin pick; next state AR. Nothing is forwarded in IDLE. Arbitration costs one cycle.
  - AR:
    - s_ar* = granted master's ar* (combinational forward); s_arvalid = m[grant]_arvalid.
    - m[grant]_arready = s_arready; the other master's arready = 0.
    - On s_arvalid & s_arready: latch len_r = arlen, clear beat_cnt, go to R.
  - R:
    - m[grant]_r* = s_r*; s_rready = m[grant]_rready. The other master sees rvalid = 0, rdata/rresp/rid/rlast = 0.
    - Each beat (s_rvalid & s_rready): beat_cnt += 1 (8-bit, wraps at 256).
    - On a beat with rlast: if beat_cnt != len_r, set err_len (sticky until reset). Then last_grant = grant; go to IDLE.
    - A beat with beat_cnt == len_r and no rlast also sets err_len. The burst keeps waiting for rlast.
- Round-robin pick:
  - Exactly one requester: that requester wins.
  - Both requesting: the one that is not last_grant wins.
- Grant is held from IDLE exit until the rlast handshake. A new arvalid from either master mid-burst is ignored (arready = 0).
- A granted master that drops arvalid in AR (protocol violation) keeps the grant. The arbiter waits in AR.
- s_arvalid is never asserted in IDLE or R. Minimum turnaround is rlast beat, then IDLE (1 cycle), then next AR.
- No combinational path from s_rvalid to s_arvalid.
- Reset asserted mid-burst: immediate return to IDLE. Partial beats are dropped. The masters are reset in the same domain.

Decomposition:
- Shared package axi_arb_pkg holds:
  - state_t enum {ST_IDLE, ST_AR, ST_R}, one-hot 3-bit.
  - Constants M_IFU = 1'b0, M_LSU = 1'b1.
  - AXI burst encodings BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10.
- One sub-module: rr_arb2 (combinational two-way round-robin pick from req[1:0] and last_grant).
- Grant register and state stay in the top module.

Test Plan:
- Lone ICache request: m0 araddr=0x8000_0008, arlen=1, arburst=WRAP; slave returns 2 beats with rlast on beat 2 -> m0 receives both beats; m1 rvalid stays 0; err_len=0; busy returns to 0 one cycle after rlast.
- Simultaneous requests from reset (PRIO_M1=1): m0 and m1 both raise arvalid in the same cycle -> m1 granted first. After its rlast, m0 is granted. Order is LSU, IFU.
- Continuous contention over 4 bursts with arvalid held on both -> grants alternate 1,0,1,0; no burst is interleaved; each master's arready is high only within its own AR phase.
- Length mismatch: arlen=3, slave asserts rlast on beat 2 -> err_len=1 after that beat; arbiter returns to IDLE; err_len stays 1 through subsequent clean bursts until reset.
- Async reset mid-burst: assert reset between two R beats, off a clock edge -> busy, s_arvalid, s_rready and all mN_rvalid go 0 immediately. After release, a fresh m0 request is served normally.
- Backpressure: m1 holds rready=0 for 3 cycles while s_rvalid=1 -> s_rready=0 for those cycles; rdata is passed through unchanged when the beat is accepted; beat_cnt is not incremented without the handshake.
